// File: rtl/pmci_spi_resp_pkg.sv
// Package: pmci_spi_resp_pkg
// Shared definitions for the PMCI egress SPI responder. It holds the command
// encodings, the SPI frame field widths, the FSM state type, and a helper that
// returns the index of the last bit of each counted frame field.
package pmci_spi_resp_pkg;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 16;
    localparam int DUMMY_W = 8;
    localparam int DATA_W  = 32;

    localparam logic [CMD_W-1:0] CMD_WR = 8'h02;
    localparam logic [CMD_W-1:0] CMD_RD = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_DUMMY = 3'd4,
        ST_RDATA = 3'd5,
        ST_SKIP  = 3'd6
    } state_t;

    // Bit index (0-based) of the final bit of the field a state is collecting.
    // SKIP and IDLE never complete a field, so they return a value that the
    // bit counter never reaches.
    function automatic logic [5:0] field_last(input state_t st);
        case (st)
            ST_CMD:             return 6'(CMD_W - 1);
            ST_ADDR:            return 6'(ADDR_W - 1);
            ST_DUMMY:           return 6'(DUMMY_W - 1);
            ST_WDATA, ST_RDATA: return 6'(DATA_W - 1);
            default:            return 6'h3F;
        endcase
    endfunction

endpackage

// File: rtl/pmci_spi_resp_sync.sv
// Module: pmci_spi_resp_sync
// Brings the asynchronous SPI pins into the clk domain through SYNC_STG flops,
// then detects edges on the synchronized sclk and csn.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   sclk, csn, mosi      raw SPI pins
//   sclk_rise/sclk_fall  1-cycle pulses on synchronized sclk edges
//   csn_fall/csn_rise    1-cycle pulses on synchronized csn edges
//   mosi_s               synchronized MOSI, aligned with the sclk edge pulses
module pmci_spi_resp_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s
);

    logic [SYNC_STG-1:0] sclk_ff;
    logic [SYNC_STG-1:0] csn_ff;
    logic [SYNC_STG-1:0] mosi_ff;
    logic                sclk_d;
    logic                csn_d;

    // The csn chain resets to 0 on purpose. If csn is still low when reset
    // releases, no falling edge is seen, so a half-finished frame cannot
    // restart. The responder waits for the next real csn fall. A csn that is
    // high at release shows up as a rise, and IDLE ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff <= '0;
            csn_ff  <= '0;
            mosi_ff <= '0;
            sclk_d  <= 1'b0;
            csn_d   <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STG-2:0], sclk};
            csn_ff  <= {csn_ff[SYNC_STG-2:0], csn};
            mosi_ff <= {mosi_ff[SYNC_STG-2:0], mosi};
            sclk_d  <= sclk_ff[SYNC_STG-1];
            csn_d   <= csn_ff[SYNC_STG-1];
        end
    end

    assign sclk_rise = sclk_ff[SYNC_STG-1] & ~sclk_d;
    assign sclk_fall = ~sclk_ff[SYNC_STG-1] & sclk_d;
    assign csn_fall  = ~csn_ff[SYNC_STG-1] & csn_d;
    assign csn_rise  = csn_ff[SYNC_STG-1] & ~csn_d;
    assign mosi_s    = mosi_ff[SYNC_STG-1];

endmodule

// File: rtl/pmci_spi_egress_responder.sv
// Module: pmci_spi_egress_responder
// SPI mode-0 target for the PMCI egress link. The FPGA is the SPI master.
// Frames are cmd[7:0] followed by a 16-bit word address. A write frame (0x02)
// then carries 32-bit data words. A read frame (0x03) carries 8 dummy bits
// and then returns 32-bit data words. The address auto-increments by one word
// per data word and wraps at 2**AW. Any other command makes the responder
// ignore the rest of the frame.
// Ports:
//   clk, rst_n                 system clock (>= 4x sclk), async active-low reset
//   spi_sclk/spi_csn/spi_mosi  SPI inputs
//   spi_miso, spi_miso_oe      SPI output; MISO is driven only while returning read data
//   loc_addr/loc_wr/loc_wdata  local-side register-file write port
//   loc_rdata                  local read data, registered, 1-cycle latency
//   spi_wr_evt                 pulse per SPI word committed to the register file
//   frame_err                  pulse on an aborted or illegal frame
//   err_cnt                    saturating count of frame_err, present only when
//                              SPI_RESP_ERR_CNT_EN is defined
module pmci_spi_egress_responder
    import pmci_spi_resp_pkg::*;
#(
    parameter int AW       = 8,
    parameter int SYNC_STG = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_sclk,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic [AW-1:0] loc_addr,
    input  logic          loc_wr,
    input  logic [31:0]   loc_wdata,
    output logic [31:0]   loc_rdata,
    output logic          spi_wr_evt,
    output logic          frame_err
`ifdef SPI_RESP_ERR_CNT_EN
    ,
    output logic [15:0]   err_cnt
`endif
);

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

    pmci_spi_resp_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .csn       (spi_csn),
        .mosi      (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .mosi_s    (mosi_s)
    );

    state_t              state;
    logic [5:0]          bit_cnt;
    logic [DATA_W-2:0]   sh_in;
    logic [DATA_W-1:0]   sh_next;
    logic [CMD_W-1:0]    cmd_q;
    logic [AW-1:0]       addr_q;
    logic [DATA_W-1:0]   miso_sh;
    logic                load_pend;
    logic                miso_oe;
    logic                spi_we;
    logic [AW-1:0]       we_addr;
    logic [DATA_W-1:0]   we_data;
    logic                frame_err_q;
    logic                field_done;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   mem [0:(1<<AW)-1];

    // The incoming shift value includes the bit being sampled now, so a field
    // completes on the same clock as its last rising edge.
    assign sh_next    = {sh_in, mosi_s};
    assign field_done = (bit_cnt == field_last(state));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            sh_in       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            miso_sh     <= '0;
            load_pend   <= 1'b0;
            miso_oe     <= 1'b0;
            spi_we      <= 1'b0;
            we_addr     <= '0;
            we_data     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            spi_we      <= 1'b0;
            frame_err_q <= 1'b0;
            if (csn_rise && state != ST_IDLE) begin
                // End of frame. A partially shifted field is dropped. Only a
                // field boundary counts as a clean end, and SKIP is never clean.
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                miso_oe   <= 1'b0;
                load_pend <= 1'b0;
                miso_sh   <= '0;
                case (state)
                    ST_SKIP: frame_err_q <= 1'b1;
                    ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA:
                        if (bit_cnt != '0) frame_err_q <= 1'b1;
                    default: ;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csn_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            miso_sh <= '0;
                        end
                    end
                    ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY: begin
                        if (sclk_rise) begin
                            sh_in   <= sh_next[DATA_W-2:0];
                            bit_cnt <= field_done ? 6'd0 : bit_cnt + 6'd1;
                            if (field_done) begin
                                case (state)
                                    ST_CMD: begin
                                        cmd_q <= sh_next[CMD_W-1:0];
                                        state <= ST_ADDR;
                                    end
                                    ST_ADDR: begin
                                        addr_q <= sh_next[AW-1:0];
                                        if (cmd_q == CMD_WR)      state <= ST_WDATA;
                                        else if (cmd_q == CMD_RD) state <= ST_DUMMY;
                                        else                      state <= ST_SKIP;
                                    end
                                    ST_WDATA: begin
                                        spi_we  <= 1'b1;
                                        we_addr <= addr_q;
                                        we_data <= sh_next;
                                        addr_q  <= addr_q + AW'(1);
                                    end
                                    default: begin
                                        // DUMMY complete: rd_word already holds
                                        // mem[addr_q]. It loads on the next fall.
                                        state     <= ST_RDATA;
                                        miso_oe   <= 1'b1;
                                        load_pend <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= field_done ? 6'd0 : bit_cnt + 6'd1;
                            if (field_done) begin
                                // The next word is fetched two clocks before the
                                // fall that loads it, which keeps bursts gapless.
                                addr_q    <= addr_q + AW'(1);
                                load_pend <= 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (load_pend) begin
                                miso_sh   <= rd_word;
                                load_pend <= 1'b0;
                            end else begin
                                miso_sh <= {miso_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: ; // SKIP: ignore everything until csn rises
                endcase
            end
        end
    end

    // Register file. The SPI write is issued last, so it wins a same-address
    // collision with the local port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            loc_rdata <= '0;
            rd_word   <= '0;
        end else begin
            if (loc_wr) mem[loc_addr] <= loc_wdata;
            if (spi_we) mem[we_addr]  <= we_data;
            loc_rdata <= mem[loc_addr];
            rd_word   <= mem[addr_q];
        end
    end

`ifdef SPI_RESP_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (frame_err_q && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

    assign spi_miso_oe = miso_oe;
    assign spi_miso    = miso_oe & miso_sh[DATA_W-1];
    assign spi_wr_evt  = spi_we;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pmci_spi_egress_responder.sv
module tb_pmci_spi_egress_responder;

    localparam int AW   = 8;
    localparam int HALF = 40; // half sclk period in ns; clk is 10 ns

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_sclk, spi_csn, spi_mosi;
    logic          spi_miso, spi_miso_oe;
    logic [AW-1:0] loc_addr;
    logic          loc_wr;
    logic [31:0]   loc_wdata;
    logic [31:0]   loc_rdata;
    logic          spi_wr_evt, frame_err;
`ifdef SPI_RESP_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_evt_cnt = 0;
    int ferr_cnt   = 0;
    int oe_hi = 0;
    int oe_lo = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pmci_spi_egress_responder #(.AW(AW), .SYNC_STG(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .loc_addr    (loc_addr),
        .loc_wr      (loc_wr),
        .loc_wdata   (loc_wdata),
        .loc_rdata   (loc_rdata),
        .spi_wr_evt  (spi_wr_evt),
        .frame_err   (frame_err)
`ifdef SPI_RESP_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always @(posedge clk) begin
        if (spi_wr_evt === 1'b1) wr_evt_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic spi_begin();
        spi_csn = 1'b0;
        #HALF;
    endtask

    // Shift n bits of val, MSB first. MISO is captured and OE is tallied at each rise.
    task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            #HALF;
            spi_sclk = 1'b1;
            got = {got[30:0], spi_miso};
            if (spi_miso_oe === 1'b1) oe_hi++; else oe_lo++;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        #HALF;
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_write1(input logic [15:0] addr, input logic [31:0] data);
        logic [31:0] d;
        spi_begin();
        spi_bits(32'h02, 8, d);
        spi_bits({16'h0, addr}, 16, d);
        spi_bits(data, 32, d);
        spi_end();
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        loc_addr = a; loc_wdata = d; loc_wr = 1'b1;
        @(negedge clk);
        loc_wr = 1'b0;
    endtask

    task automatic loc_read(input logic [AW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        loc_addr = a;
        @(negedge clk);
        d = loc_rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b exp 0", spi_miso_oe); end
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b exp 0", spi_miso); end
        checks++; if (spi_wr_evt !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: wr_evt=%b frame_err=%b exp 0", spi_wr_evt, frame_err); end
`ifdef SPI_RESP_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
`endif
        exp_q.push_back(32'h0);
        loc_read(8'h10, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL reset_mem: got %h exp 0", d); end
    endtask

    task automatic test_write();
        logic [31:0] d;
        int w0;
        w0 = wr_evt_cnt;
        exp_q.push_back(32'hDEADBEEF);
        spi_write1(16'h0010, 32'hDEADBEEF);
        loc_read(8'h10, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL write_data: got %h exp deadbeef", d); end
        checks++; if (wr_evt_cnt - w0 !== 1) begin failures++; $display("FAIL write_evt: got %0d exp 1", wr_evt_cnt - w0); end
    endtask

    task automatic test_read();
        logic [31:0] d;
        loc_write(8'h20, 32'hA5A5_0F0F);
        exp_q.push_back(32'hA5A5_0F0F);
        oe_hi = 0; oe_lo = 0;
        spi_begin();
        spi_bits(32'h03, 8, d);
        spi_bits(32'h0020, 16, d);
        spi_bits(32'h0, 8, d);
        checks++; if (oe_hi !== 0 || oe_lo !== 32) begin failures++; $display("FAIL read_oe_hdr: hi=%0d lo=%0d exp hi=0 lo=32", oe_hi, oe_lo); end
        spi_bits(32'h0, 32, d);
        checks++; if (oe_hi !== 32) begin failures++; $display("FAIL read_oe_data: hi=%0d exp 32", oe_hi); end
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL read_data: got %h exp a5a50f0f", d); end
        spi_end();
        checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin failures++; $display("FAIL read_oe_end: oe=%b miso=%b exp 0 0", spi_miso_oe, spi_miso); end
    endtask

    task automatic test_burst_wrap();
        logic [31:0] d;
        int w0;
        w0 = wr_evt_cnt;
        exp_q.push_back(32'h1111_1111);
        exp_q.push_back(32'h2222_2222);
        spi_begin();
        spi_bits(32'h02, 8, d);
        spi_bits(32'h00FF, 16, d);
        spi_bits(32'h1111_1111, 32, d);
        spi_bits(32'h2222_2222, 32, d);
        spi_end();
        loc_read(8'hFF, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL burst_ff: got %h exp 11111111", d); end
        loc_read(8'h00, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL burst_wrap_00: got %h exp 22222222", d); end
        checks++; if (wr_evt_cnt - w0 !== 2) begin failures++; $display("FAIL burst_evt: got %0d exp 2", wr_evt_cnt - w0); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int w0, f0;
        loc_write(8'h05, 32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        w0 = wr_evt_cnt; f0 = ferr_cnt;
        spi_begin();
        spi_bits(32'h02, 8, d);
        spi_bits(32'h0005, 16, d);
        spi_bits(32'hFFFF_FFFF, 12, d);
        spi_end();
        loc_read(8'h05, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL abort_mem: got %h exp 12345678", d); end
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL abort_ferr: got %0d exp 1", ferr_cnt - f0); end
        checks++; if (wr_evt_cnt - w0 !== 0) begin failures++; $display("FAIL abort_evt: got %0d exp 0", wr_evt_cnt - w0); end
`ifdef SPI_RESP_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL abort_err_cnt: got %0d exp 1", err_cnt); end
`endif
    endtask

    task automatic test_skip();
        logic [31:0] d;
        int w0, f0;
        w0 = wr_evt_cnt; f0 = ferr_cnt;
        oe_hi = 0;
        spi_begin();
        spi_bits(32'h9F, 8, d);
        spi_bits(32'h0040, 16, d);
        spi_bits(32'hFFFF_FFFF, 32, d);
        spi_end();
        checks++; if (oe_hi !== 0) begin failures++; $display("FAIL skip_oe: hi=%0d exp 0", oe_hi); end
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL skip_ferr: got %0d exp 1", ferr_cnt - f0); end
        checks++; if (wr_evt_cnt - w0 !== 0) begin failures++; $display("FAIL skip_evt: got %0d exp 0", wr_evt_cnt - w0); end
`ifdef SPI_RESP_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd2) begin failures++; $display("FAIL skip_err_cnt: got %0d exp 2", err_cnt); end
`endif
        // The following valid write uses upper address bits, which must be ignored.
        exp_q.push_back(32'hCAFE_F00D);
        spi_write1(16'hAB40, 32'hCAFE_F00D);
        loc_read(8'h40, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL skip_next_write: got %h exp cafef00d", d); end
        checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL skip_next_ferr: got %0d exp 1", ferr_cnt - f0); end
    endtask

    task automatic test_collide();
        logic [31:0] d;
        logic seen;
        seen = 1'b0;
        exp_q.push_back(32'h600D_D00D);
        fork
            spi_write1(16'h0030, 32'h600D_D00D);
            begin
                loc_addr = 8'h30; loc_wdata = 32'h0; loc_wr = 1'b1;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    if (spi_wr_evt === 1'b1) seen = 1'b1;
                end
                @(posedge clk);
                #1 loc_wr = 1'b0;
            end
        join
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL collide_evt: spi_wr_evt seen=%b exp 1", seen); end
        loc_read(8'h30, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL collide_data: got %h exp 600dd00d", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        int f0;
        spi_begin();
        spi_bits(32'h03, 8, d);
        spi_bits(32'h0020, 16, d);
        spi_bits(32'h0, 8, d);
        spi_bits(32'h0, 10, d);
        checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL midrd_oe_before: got %b exp 1", spi_miso_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin failures++; $display("FAIL midrd_oe_reset: oe=%b miso=%b exp 0 0", spi_miso_oe, spi_miso); end
        #19;
        rst_n = 1'b1;
        f0 = ferr_cnt;
        oe_hi = 0;
        spi_bits(32'hFF, 8, d);
        spi_end();
        checks++; if (oe_hi !== 0) begin failures++; $display("FAIL midrd_idle_oe: hi=%0d exp 0", oe_hi); end
        checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL midrd_idle_ferr: got %0d exp 0", ferr_cnt - f0); end
        exp_q.push_back(32'h0);
        loc_read(8'h20, d);
        checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL midrd_mem_cleared: got %h exp 0", d); end
`ifdef SPI_RESP_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL midrd_err_cnt: got %0d exp 0", err_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] w [2];
        w[0] = $urandom_range(32'hFFFF, 0) << 16 | $urandom_range(32'hFFFF, 0);
        w[1] = $urandom_range(32'hFFFF, 0) << 16 | $urandom_range(32'hFFFF, 0);
        loc_write(8'h50, w[0]);
        loc_write(8'h51, w[1]);
        exp_q.push_back(w[0]);
        exp_q.push_back(w[1]);
        spi_begin();
        spi_bits(32'h03, 8, d);
        spi_bits(32'h0050, 16, d);
        spi_bits(32'h0, 8, d);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e;
            spi_bits(32'h0, 32, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL b2b_word%0d: got %h exp %h", k, d, e); end
        end
        spi_end();
    endtask

    initial begin
        rst_n = 1'b0; spi_sclk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        loc_addr = '0; loc_wr = 1'b0; loc_wdata = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_abort();
        test_skip();
        test_collide();
        test_reset_mid_read();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left exp 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
